bit_scanner: RTL and testbench
==============================

BIT_SCANNER -- requirements
Module: bit_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; takes effect only on a rising clock edge.
REQ-004 start  input  1  request to scan the value on in; accepted only while ready=1.
REQ-005 in  input  32  word to scan; sampled on the accepting edge only.
REQ-006 ready  output  1  block idle and able to accept start.
REQ-007 out_valid  output  1  index holds the position of a set bit.
REQ-008 out_ready  input  1  consumer accepts index; a beat transfers when out_valid=1 and out_ready=1 on an edge.
REQ-009 index  output  5  bit position (0..31) of the current set bit.
REQ-010 done  output  1  one-cycle pulse marking the end of a scan.
REQ-011 zero  output  1  scanned word had no set bits; valid from the done cycle.
REQ-012 count  output  6  number of set bits emitted in the scan (0..32).

Function
REQ-013 The block SHALL scan a word LSB-first and emit the index of every set bit, in ascending order, one per handshake beat.
REQ-014 The state machine SHALL have three states: IDLE, SCAN and DONE; ready=1 only in IDLE.
REQ-015 In IDLE with start=1 on an edge: word<=in, ptr<=0, count<=0, zero<=0, state<=SCAN.
REQ-016 start SHALL be ignored in SCAN and DONE; in SHALL NOT be resampled during a scan.
REQ-017 In SCAN: out_valid = word[ptr] (combinational from registered state); index = ptr.
REQ-018 In SCAN with word[ptr]=0: ptr advances on the next edge, so each clear bit costs exactly one cycle.
REQ-019 In SCAN with word[ptr]=1: ptr, index and out_valid SHALL hold until out_ready=1; on the accepting edge, count increments by 1 and ptr advances.
REQ-020 out_valid SHALL NOT drop and index SHALL NOT change while a beat is stalled.
REQ-021 When ptr=31 and its bit is completed (clear, or set and accepted): state<=DONE and zero<=(updated count==0); ptr SHALL NOT wrap.
REQ-022 In DONE: done=1 for exactly one cycle, out_valid=0; next state is IDLE unconditionally.
REQ-023 count and zero SHALL hold their final values after DONE until the next accepted start.
REQ-024 Latency with out_ready held at 1: the SCAN state lasts exactly 32 cycles; the done pulse occurs on the 33rd cycle after the accepting edge.
REQ-025 Each stalled cycle SHALL extend the total latency by exactly one cycle.
REQ-026 count SHALL be 6 bits wide; a value of 32 SHALL be representable without overflow.
REQ-027 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-028 On reset: state=IDLE, ready=1, out_valid=0, done=0, zero=0, count=0, index=0, ptr=0, word=0.
REQ-029 Reset SHALL abort any scan or stalled beat in progress; no done pulse SHALL follow an aborted scan.
REQ-030 Reset SHALL take priority over start on the same edge.

Verification
REQ-031 in=0x00000000, start, out_ready=1 -> out_valid never asserted; done on cycle 33; zero=1; count=0.
REQ-032 in=0x80000001, out_ready=1 -> index=0 on SCAN cycle 1; index=31 on SCAN cycle 32; count=2; zero=0.
REQ-033 in=0x00000006, out_ready=0 for 3 cycles at index=1 -> index holds 1 with out_valid=1; index=2 follows; done on cycle 36; count=2.
REQ-034 in=0xFFFFFFFF, out_ready=1 -> 32 consecutive beats with indices 0..31; count=32; zero=0.
REQ-035 Reset asserted during SCAN -> next cycle ready=1, out_valid=0, count=0; no done pulse; a new start is accepted normally afterwards.
REQ-036 start pulsed with a different in during SCAN -> ignored; the original word's indices are emitted unchanged.

Source files
------------

// File: rtl/bit_scanner_if.sv
// ============================================================================
//  Module      : bit_scanner_if
//  Description : Handshake bundle for bit_scanner. The requester side drives
//                start/in and the downstream out_ready; the scanner side
//                returns ready, the index beat stream and the end-of-scan
//                status (done/zero/count).
//  Modports    : master - requester/consumer (testbench or parent logic)
//                slave  - the bit_scanner itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_scanner_if;
  logic        start;      // scan request, honoured only while ready=1
  logic [31:0] in;         // word to scan, sampled on the accepting edge
  logic        ready;      // scanner idle
  logic        out_valid;  // index holds a set-bit position
  logic        out_ready;  // consumer takes the current index
  logic [4:0]  index;      // current bit position
  logic        done;       // one-cycle end-of-scan pulse
  logic        zero;       // scanned word had no set bits
  logic [5:0]  count;      // set bits emitted so far / in last scan

  modport master (
    output start,
    output in,
    output out_ready,
    input  ready,
    input  out_valid,
    input  index,
    input  done,
    input  zero,
    input  count
  );

  modport slave (
    input  start,
    input  in,
    input  out_ready,
    output ready,
    output out_valid,
    output index,
    output done,
    output zero,
    output count
  );
endinterface

`default_nettype wire

// File: rtl/bit_scanner.sv
// ============================================================================
//  Module      : bit_scanner
//  Description : Scans a 32-bit word LSB-first and emits the position of every
//                set bit, one per valid/ready beat, in ascending order. A clear
//                bit costs one cycle; a set bit holds until accepted. A one-
//                cycle done pulse ends the scan, after which count and zero
//                report the number of emitted bits and the empty-word flag.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset, aborts any scan
//                bus  - bit_scanner_if.slave (start/in/ready, index stream,
//                       done/zero/count status)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_scanner (
  input  wire           clk,
  input  wire           rst,
  bit_scanner_if.slave  bus
);

  localparam logic [4:0] c_last_ptr = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_word;
  logic [4:0]  r_ptr;
  logic [5:0]  r_count;
  logic        r_zero;

  logic        w_bit;
  logic        w_advance;
  logic [5:0]  w_count_next;

  // Bit under the pointer; while it is set the beat is presented downstream.
  assign w_bit = r_word[r_ptr];

  // The pointer moves on when the current bit is finished: a clear bit is
  // finished immediately, a set bit only once the consumer accepts it.
  assign w_advance = (r_state == S_SCAN) && (!w_bit || bus.out_ready);

  // Count including the beat completing on this edge; used so the zero flag
  // at the final bit reflects bit 31 as well.
  assign w_count_next = r_count + {5'd0, w_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_word  <= 32'd0;
      r_ptr   <= 5'd0;
      r_count <= 6'd0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_word  <= bus.in;
            r_ptr   <= 5'd0;
            r_count <= 6'd0;
            r_zero  <= 1'b0;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_advance) begin
            r_count <= w_count_next;
            // The pointer parks on 31 at the end rather than wrapping.
            if (r_ptr == c_last_ptr) begin
              r_zero  <= (w_count_next == 6'd0);
              r_state <= S_DONE;
            end else begin
              r_ptr <= r_ptr + 5'd1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign bus.ready     = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_SCAN) && w_bit;
  assign bus.index     = r_ptr;
  assign bus.done      = (r_state == S_DONE);
  assign bus.zero      = r_zero;
  assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bit_scanner.sv
// ============================================================================
//  Module      : tb_bit_scanner
//  Description : Scoreboard bench for bit_scanner. Directed scans push the
//                expected index beats and end-of-scan status into queues; a
//                monitor on the falling edge pops and compares them as the
//                scanner presents beats and done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_scanner;

  typedef struct {
    int idx;
    int off;
  } beat_t;

  typedef struct {
    int cnt;
    bit zr;
    int off;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   cur_accept = 0;
  int   tests = 0;
  int   fails = 0;

  beat_t exp_beats[$];
  done_t exp_done[$];

  bit_scanner_if bus ();

  bit_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  bit held = 1'b0;
  int held_idx = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_hold_valid", int'(bus.out_valid), 1);
          chk("stall_hold_index", int'(bus.index), held_idx);
        end
        held     = bus.out_valid && !bus.out_ready;
        held_idx = int'(bus.index);

        if (bus.out_valid && bus.out_ready) begin
          if (exp_beats.size() == 0) begin
            chk("unexpected_beat_index", int'(bus.index), -1);
          end else begin
            beat_t b;
            b = exp_beats.pop_front();
            chk("beat_index", int'(bus.index), b.idx);
            chk("beat_offset", cyc - cur_accept, b.off);
          end
        end

        if (bus.done) begin
          if (exp_done.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            done_t d;
            d = exp_done.pop_front();
            chk("done_count", int'(bus.count), d.cnt);
            chk("done_zero", int'(bus.zero), int'(d.zr));
            chk("done_offset", cyc - cur_accept, d.off);
            chk("done_valid_low", int'(bus.out_valid), 0);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  // Entered just after a rising edge with the scanner idle. stall_bit/nstall
  // hold out_ready low for nstall cycles starting when that (set) bit is
  // presented; inject_t >= 0 pulses start with inject_w during the scan.
  task automatic run_scan(input logic [31:0] w, input int stall_bit,
                          input int nstall, input int inject_t,
                          input logic [31:0] inject_w);
    int c;
    c = 0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.in        = w;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.in     = ~w;            // changing in after acceptance must not matter
    cur_accept = cyc;
    for (int b = 0; b < 32; b++) begin
      if (w[b]) begin
        beat_t e;
        e.idx = b;
        e.off = b + ((nstall > 0 && b >= stall_bit) ? nstall : 0);
        exp_beats.push_back(e);
        c++;
      end
    end
    begin
      done_t d;
      d.cnt = c;
      d.zr  = (c == 0);
      d.off = 32 + nstall;
      exp_done.push_back(d);
    end
    for (int t = 0; t < 34 + nstall; t++) begin
      bus.out_ready = !(t >= stall_bit && t < stall_bit + nstall);
      bus.start     = (t == inject_t);
      bus.in        = (t == inject_t) ? inject_w : ~w;
      @(posedge clk);
      #1;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    chk("post_ready", int'(bus.ready), 1);
    chk("post_done_low", int'(bus.done), 0);
    chk("post_count_hold", int'(bus.count), c);
    chk("post_zero_hold", int'(bus.zero), (c == 0) ? 1 : 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in        = 32'd0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_zero", int'(bus.zero), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_index", int'(bus.index), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Empty word: no beats, done after 33 cycles, zero set.
    run_scan(32'h0000_0000, -1, 0, -1, 32'd0);
    // Both boundary bits.
    run_scan(32'h8000_0001, -1, 0, -1, 32'd0);
    // Three stalled cycles on bit 1.
    run_scan(32'h0000_0006, 1, 3, -1, 32'd0);
    // Every bit set, count reaches 32.
    run_scan(32'hFFFF_FFFF, -1, 0, -1, 32'd0);
    // start pulsed mid-scan with a different word is ignored.
    run_scan(32'h0001_0010, -1, 0, 5, 32'hFFFF_FFFF);
    // Stall on the last bit.
    run_scan(32'h8000_0100, 31, 2, -1, 32'd0);

    // Reset mid-scan, together with a start that must lose to reset.
    bus.start = 1'b1;
    bus.in    = 32'hF0F0_F0F0;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    cur_accept = cyc;
    for (int b = 4; b < 8; b++) begin
      beat_t e;
      e.idx = b;
      e.off = b;
      exp_beats.push_back(e);
    end
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("abort_in_scan", int'(bus.ready), 0);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.in    = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_valid", int'(bus.out_valid), 0);
    chk("abort_count", int'(bus.count), 0);
    @(posedge clk);
    #1;
    chk("abort_start_ignored", int'(bus.ready), 1);
    repeat (40) begin
      @(posedge clk);
      #1;
    end

    // Normal operation after the abort.
    run_scan(32'h0000_0081, -1, 0, -1, 32'd0);

    chk("beats_left", exp_beats.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
